// File: rtl/seq_multiplier.sv
// Unsigned shift-and-add multiplier, one partial product per clock.
// Datapath arithmetic is built from the gate primitives defined below.

module and_gate (
    input  logic a_i,
    input  logic b_i,
    output logic y_o
);
    assign y_o = a_i & b_i;
endmodule

module or_gate (
    input  logic a_i,
    input  logic b_i,
    output logic y_o
);
    assign y_o = a_i | b_i;
endmodule

module xor_gate (
    input  logic a_i,
    input  logic b_i,
    output logic y_o
);
    assign y_o = a_i ^ b_i;
endmodule

module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);
    logic x1, g, p;

    xor_gate u_x1 (.a_i(a_i), .b_i(b_i),  .y_o(x1));
    xor_gate u_x2 (.a_i(x1),  .b_i(ci_i), .y_o(s_o));
    and_gate u_a1 (.a_i(a_i), .b_i(b_i),  .y_o(g));
    and_gate u_a2 (.a_i(x1),  .b_i(ci_i), .y_o(p));
    or_gate  u_o1 (.a_i(g),   .b_i(p),    .y_o(co_o));
endmodule

module seq_multiplier #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  m_q, a_q, q_q;
    logic              c_q;
    logic [CntW-1:0]   cnt_q;

    logic [WIDTH-1:0]  addend, sum;
    logic [WIDTH:0]    carry;
    logic [WIDTH-1:0]  a_shift, q_shift;
    logic              last;

    // C is zero between iterations, so feeding it in as carry-in leaves A + M unchanged.
    assign carry[0] = c_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_add
        and_gate u_pp (
            .a_i (m_q[i]),
            .b_i (q_q[0]),
            .y_o (addend[i])
        );
        full_adder u_fa (
            .a_i  (a_q[i]),
            .b_i  (addend[i]),
            .ci_i (carry[i]),
            .s_o  (sum[i]),
            .co_o (carry[i+1])
        );
    end

    // {C,A,Q} >> 1 after the conditional add; a zero enters at C.
    assign a_shift = {carry[WIDTH], sum[WIDTH-1:1]};
    assign q_shift = {sum[0], q_q[WIDTH-1:1]};
    assign last    = (cnt_q == CntW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            m_q     <= '0;
            a_q     <= '0;
            c_q     <= 1'b0;
            q_q     <= '0;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    done <= 1'b0;
                    if (start) begin
                        m_q     <= a;
                        q_q     <= b;
                        a_q     <= '0;
                        c_q     <= 1'b0;
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= StRun;
                    end else begin
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                StRun: begin
                    a_q   <= a_shift;
                    q_q   <= q_shift;
                    c_q   <= 1'b0;
                    cnt_q <= cnt_q + 1'b1;
                    if (last) begin
                        product <= {a_shift, q_shift};
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= StDone;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_multiplier.sv
// Directed and randomised checks of seq_multiplier at WIDTH = 4, 8 and 16.

module tb_seq_multiplier;
    logic        clk;
    logic        rst;
    logic        start, start4, start16;
    logic [7:0]  a, b;
    logic [3:0]  a4, b4;
    logic [15:0] a16, b16;
    logic        busy, done, busy4, done4, busy16, done16;
    logic [15:0] product;
    logic [7:0]  product4;
    logic [31:0] product16;

    int n_checks = 0;
    int n_errors = 0;

    seq_multiplier #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .product(product)
    );
    seq_multiplier #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .product(product4)
    );
    seq_multiplier #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .product(product16)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Runs one WIDTH=8 operation; optionally raises a stray start before edge `inject`.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic [15:0] exp,
                          input int inject, input string tag);
        int lat;
        lat = 0;
        @(negedge clk);
        a = ta; b = tb_v; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, " busy after E0"}, busy, 1);
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            if (k == inject) begin
                start = 1'b1; a = 8'd7; b = 8'd7;
            end
            @(negedge clk);
            start = 1'b0;
            if (done) lat = k;
        end
        check({tag, " latency"}, lat, 8);
        check({tag, " product"}, product, exp);
        check({tag, " busy at done"}, busy, 0);
    endtask

    initial begin
        int ndone, lat;
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        start4 = 1'b0; a4 = '0; b4 = '0;
        start16 = 1'b0; a16 = '0; b16 = '0;
        #12;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset product", product, 0);
        @(negedge clk);
        rst = 1'b0;

        run_op(8'd13, 8'd11, 16'h008F, 0, "basic");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("basic hold", product, 16'h008F);
            check("basic no done", done, 0);
        end

        run_op(8'd255, 8'd255, 16'hFE01, 0, "255x255");
        run_op(8'd0, 8'd200, 16'h0000, 0, "0x200");
        run_op(8'd1, 8'd255, 16'h00FF, 0, "1x255");

        run_op(8'd3, 8'd5, 16'd15, 3, "ignored start");
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("ignored start second done", ndone, 0);
        check("ignored start hold", product, 16'd15);

        // Abort mid-operation: reset must clear product without leaking the partial result.
        @(negedge clk);
        a = 8'd200; b = 8'd100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort busy", busy, 0);
        check("abort product", product, 0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        check("abort stays idle", ndone, 0);
        check("abort product after", product, 0);
        run_op(8'd6, 8'd7, 16'd42, 0, "6x7");

        // Back-to-back: second start lands in the DONE cycle.
        run_op(8'd9, 8'd9, 16'd81, 0, "b2b first");
        a = 8'd12; b = 8'd12; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b busy", busy, 1);
        check("b2b done low", done, 0);
        check("b2b product held", product, 16'd81);
        lat = 0;
        for (int k = 2; k <= 40 && lat == 0; k++) begin
            @(negedge clk);
            if (done) lat = k;
        end
        check("b2b spacing", lat, 9);
        check("b2b product", product, 16'd144);

        // Asynchronous reset between clock edges with a nonzero product held.
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async rst busy", busy, 0);
        check("async rst done", done, 0);
        check("async rst product", product, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst hold", {busy, done, product}, 0);
        end
        rst = 1'b0;

        for (int n = 0; n < 200; n++) begin
            logic [7:0]  e4;
            logic [15:0] e8;
            logic [31:0] e16;
            logic [7:0]  g4;
            logic [15:0] g8;
            logic [31:0] g16;
            logic        s4, s8, s16;
            @(negedge clk);
            a4 = 4'($urandom); b4 = 4'($urandom);
            a = 8'($urandom); b = 8'($urandom);
            a16 = 16'($urandom); b16 = 16'($urandom);
            e4 = {4'b0, a4} * {4'b0, b4};
            e8 = {8'b0, a} * {8'b0, b};
            e16 = {16'b0, a16} * {16'b0, b16};
            start4 = 1'b1; start = 1'b1; start16 = 1'b1;
            @(negedge clk);
            start4 = 1'b0; start = 1'b0; start16 = 1'b0;
            s4 = 1'b0; s8 = 1'b0; s16 = 1'b0;
            g4 = '0; g8 = '0; g16 = '0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (done4) begin s4 = 1'b1; g4 = product4; end
                if (done) begin s8 = 1'b1; g8 = product; end
                if (done16) begin s16 = 1'b1; g16 = product16; end
            end
            check("sweep w4", {s4, g4}, {1'b1, e4});
            check("sweep w8", {s8, g8}, {1'b1, e8});
            check("sweep w16", {s16, g16}, {1'b1, e16});
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
